// File: rtl/uart_rx_ctrl_fsm.sv
// ============================================================================
// Module   : uart_rx_ctrl_fsm
// Brief    : UART RX frame controller. Detects the start bit, runs the
//            oversampling edge counter and data bit counter, pulses the
//            sampler/deserializer/checker enables and qualifies data_valid.
// Options  : UART_RX_FRM_ERR_CNT_EN - build the saturating stop-error
//            frame counter on frm_err_cnt (tied to 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_ctrl_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic [7:0]            frm_err_cnt
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  localparam logic [PRESCALE_W-1:0] c_P8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] c_P16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] c_P32 = PRESCALE_W'(32);
  localparam logic [3:0]            c_LAST_BIT = 4'(DATA_WIDTH - 1);

  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [3:0]            bit_q, bit_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  dv_q, dv_d;

  logic [PRESCALE_W-1:0] w_p_sel;
  logic                  w_bit_end;
  logic                  w_chk_pt;

  // Unsupported ratios fall back to 8x oversampling.
  assign w_p_sel   = (prescale == c_P16 || prescale == c_P32) ? prescale : c_P8;
  // Last oversample of the current bit, using the ratio latched for this frame.
  assign w_bit_end = (edge_q == (p_q - PRESCALE_W'(1)));
  // Edge P/2+2: the sampler's triple sample around mid-bit is complete here.
  assign w_chk_pt  = (edge_q == ((p_q >> 1) + PRESCALE_W'(2)));

  // State and frame-context registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= c_ST_IDLE;
      edge_q   <= '0;
      bit_q    <= '0;
      p_q      <= '0;
      par_en_q <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      p_q      <= p_d;
      par_en_q <= par_en_d;
      dv_q     <= dv_d;
    end
  end

  // Next-state, counter and frame-qualification logic.
  always_comb begin
    state_d  = state_q;
    edge_d   = '0;
    bit_d    = bit_q;
    p_d      = p_q;
    par_en_d = par_en_q;
    dv_d     = 1'b0;

    if (state_q != c_ST_IDLE) begin
      edge_d = w_bit_end ? '0 : edge_q + PRESCALE_W'(1);
    end

    unique case (state_q)
      c_ST_IDLE: begin
        if (!rx_in) begin
          state_d  = c_ST_START;
          bit_d    = '0;
          p_d      = w_p_sel;
          par_en_d = par_en;
        end
      end
      c_ST_START: begin
        if (w_bit_end) begin
          state_d = strt_glitch ? c_ST_IDLE : c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (w_bit_end) begin
          if (bit_q == c_LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? c_ST_PARITY : c_ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      c_ST_PARITY: begin
        if (w_bit_end) begin
          state_d = c_ST_STOP;
        end
      end
      c_ST_STOP: begin
        if (w_bit_end) begin
          state_d = c_ST_IDLE;
          // Checker results have been stable since edge K+1.
          dv_d    = !strt_glitch && !(par_en_q && par_err) && !stp_err;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
        bit_d   = '0;
      end
    endcase
  end

  // Per-state enables; check pulses fire once per bit at the check point.
  always_comb begin
    dat_samp_en = (state_q != c_ST_IDLE);
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    if (w_chk_pt) begin
      unique case (state_q)
        c_ST_START:  strt_chk_en = 1'b1;
        c_ST_DATA:   deser_en    = 1'b1;
        c_ST_PARITY: par_chk_en  = 1'b1;
        c_ST_STOP:   stp_chk_en  = 1'b1;
        default:     deser_en    = 1'b0;
      endcase
    end
  end

  assign edge_cnt   = edge_q;
  assign bit_cnt    = bit_q;
  assign data_valid = dv_q;

`ifdef UART_RX_FRM_ERR_CNT_EN
  logic [7:0] frm_cnt_q;

  // Count frames whose stop bit failed, saturating at 255.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      frm_cnt_q <= '0;
    end else if (state_q == c_ST_STOP && w_bit_end && stp_err && frm_cnt_q != 8'hFF) begin
      frm_cnt_q <= frm_cnt_q + 8'd1;
    end
  end

  assign frm_err_cnt = frm_cnt_q;
`else
  assign frm_err_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl_fsm.sv
// ============================================================================
// Module   : tb_uart_rx_ctrl_fsm
// Brief    : Self-checking bench for uart_rx_ctrl_fsm. A table of frame
//            descriptors with hand-computed pulse counts, plus directed
//            sequences for back-to-back frames, mid-frame config changes,
//            counter saturation and reset mid-frame.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_ctrl_fsm;

  localparam int PW = 6;
`ifdef UART_RX_FRM_ERR_CNT_EN
  localparam bit FRM_EN = 1'b1;
`else
  localparam bit FRM_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          par_en = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
  logic [7:0]    frm_err_cnt;

  uart_rx_ctrl_fsm #(.DATA_WIDTH(8), .PRESCALE_W(PW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .frm_err_cnt (frm_err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int exp_frm = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- event monitor (samples on the falling edge) ----------------
  logic mon_clr = 1'b0;
  int   mon_p = 8;
  int   mon_k = 6;
  int   m_samp = 0, m_deser = 0, m_strt = 0, m_par = 0, m_stp = 0, m_dv = 0;
  int   m_bad = 0, m_badbit = 0;
  logic prev_samp = 1'b0;
  int   prev_edge = 0;

  always @(negedge CLK) begin
    if (mon_clr) begin
      m_samp <= 0; m_deser <= 0; m_strt <= 0; m_par <= 0; m_stp <= 0; m_dv <= 0;
      m_bad <= 0; m_badbit <= 0;
    end else if (RST) begin
      if (dat_samp_en) m_samp <= m_samp + 1;
      if (deser_en) begin
        m_deser <= m_deser + 1;
        if (int'(bit_cnt) != (m_deser % 8)) m_badbit <= m_badbit + 1;
      end
      if (strt_chk_en) m_strt <= m_strt + 1;
      if (par_chk_en)  m_par  <= m_par + 1;
      if (stp_chk_en)  m_stp  <= m_stp + 1;
      if ((deser_en || strt_chk_en || par_chk_en || stp_chk_en) && int'(edge_cnt) != mon_k)
        m_bad <= m_bad + 1;
      if (data_valid) begin
        m_dv <= m_dv + 1;
        // data_valid must follow the stop bit end cycle, with the FSM back in IDLE.
        if (!prev_samp || prev_edge != mon_p - 1 || dat_samp_en) m_bad <= m_bad + 1;
      end
    end
    prev_samp <= dat_samp_en;
    prev_edge <= int'(edge_cnt);
  end

  task automatic clr_mon(input int p);
    mon_p   = p;
    mon_k   = p / 2 + 2;
    mon_clr = 1'b1;
    @(negedge CLK);
    @(posedge CLK);
    mon_clr = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit with_par, input logic stop_bit, input int p);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (with_par) send_bit(^d, p);
    send_bit(stop_bit, p);
    rx_in = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (dat_samp_en && t < 4000) begin
      @(negedge CLK);
      t++;
    end
    check({name, "_idle"}, int'(dat_samp_en), 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_frame(input string nm, input int samp, input int deser, input int par,
                             input int stp, input int strt, input int dv);
    check({nm, "_samp"},   m_samp,   samp);
    check({nm, "_deser"},  m_deser,  deser);
    check({nm, "_par"},    m_par,    par);
    check({nm, "_stp"},    m_stp,    stp);
    check({nm, "_strt"},   m_strt,   strt);
    check({nm, "_dv"},     m_dv,     dv);
    check({nm, "_edgeK"},  m_bad,    0);
    check({nm, "_bitcnt"}, m_badbit, 0);
    check({nm, "_frm"},    int'(frm_err_cnt), FRM_EN ? exp_frm : 0);
  endtask

  // ---------------- frame table ----------------
  typedef struct {
    int         pre;
    logic       pe;
    logic [7:0] d;
    logic       glitch;
    logic       perr;
    logic       serr;
    int         p;
    int         samp;
    int         deser;
    int         par;
    int         stp;
    int         dv;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            pre pe    data   glitch perr  serr  P   samp deser par stp dv
    tbl[0] = '{8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8,  80,  8, 0, 1, 1};
    tbl[1] = '{16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 16, 176, 8, 1, 1, 1};
    tbl[2] = '{16, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 16, 176, 8, 1, 1, 0};
    tbl[3] = '{32, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 32, 320, 8, 0, 1, 0};
    tbl[4] = '{8,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8,  8,   0, 0, 0, 0};
    tbl[5] = '{12, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 8,  80,  8, 0, 1, 1};
    tbl[6] = '{16, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 16, 160, 8, 0, 1, 1};
    tbl[7] = '{32, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 32, 352, 8, 1, 1, 1};

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_edge_cnt", int'(edge_cnt), 0);
    check("rst_bit_cnt",  int'(bit_cnt), 0);
    check("rst_pulses",   int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}), 0);
    check("rst_frm",      int'(frm_err_cnt), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      prescale    = PW'(tbl[i].pre);
      par_en      = tbl[i].pe;
      strt_glitch = tbl[i].glitch;
      par_err     = tbl[i].perr;
      stp_err     = tbl[i].serr;
      clr_mon(tbl[i].p);
      if (tbl[i].glitch) begin
        rx_in = 1'b0;
        repeat (3) @(negedge CLK);
        rx_in = 1'b1;
      end else begin
        drive_frame(tbl[i].d, tbl[i].pe, ~tbl[i].serr, tbl[i].p);
      end
      wait_idle($sformatf("v%0d", i));
      if (tbl[i].serr && !tbl[i].glitch && exp_frm < 255) exp_frm++;
      check_frame($sformatf("v%0d", i), tbl[i].samp, tbl[i].deser, tbl[i].par,
                  tbl[i].stp, 1, tbl[i].dv);
    end
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;

    // Back-to-back frames, no idle gap on the line.
    prescale = PW'(8); par_en = 1'b0;
    clr_mon(8);
    drive_frame(8'h55, 1'b0, 1'b1, 8);
    drive_frame(8'hAA, 1'b0, 1'b1, 8);
    wait_idle("b2b");
    check_frame("b2b", 160, 16, 0, 2, 2, 2);

    // par_en and prescale changed mid-frame: the latched configuration wins.
    prescale = PW'(8); par_en = 1'b1;
    clr_mon(8);
    fork
      drive_frame(8'h96, 1'b1, 1'b1, 8);
      begin
        repeat (30) @(negedge CLK);
        par_en   = 1'b0;
        prescale = PW'(32);
      end
    join
    wait_idle("cfg");
    check_frame("cfg", 88, 8, 1, 1, 1, 1);

`ifdef UART_RX_FRM_ERR_CNT_EN
    // 256 stop-error frames: counter saturates at 255.
    prescale = PW'(8); par_en = 1'b0; stp_err = 1'b1;
    clr_mon(8);
    for (int n = 0; n < 256; n++) begin
      drive_frame(8'h0F, 1'b0, 1'b0, 8);
      wait_idle("sat");
      if (exp_frm < 255) exp_frm++;
    end
    check("sat_frm", int'(frm_err_cnt), 255);
    check("sat_dv", m_dv, 0);
    stp_err = 1'b0;
`endif

    // Reset in the middle of DATA bit 3, then a fresh frame.
    prescale = PW'(8); par_en = 1'b0;
    clr_mon(8);
    rx_in = 1'b0;
    begin
      int t = 0;
      while (int'(bit_cnt) != 3 && t < 200) begin
        @(negedge CLK);
        t++;
      end
    end
    check("rst_mid_reach_bit3", int'(bit_cnt), 3);
    #2;
    RST = 1'b0;
    exp_frm = 0;
    #1;
    check("rst_mid_edge_cnt", int'(edge_cnt), 0);
    check("rst_mid_bit_cnt",  int'(bit_cnt), 0);
    check("rst_mid_pulses",   int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}), 0);
    check("rst_mid_frm",      int'(frm_err_cnt), 0);
    rx_in = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_mid_no_dv", m_dv, 0);
    clr_mon(8);
    drive_frame(8'h3A, 1'b0, 1'b1, 8);
    wait_idle("post_rst");
    check_frame("post_rst", 80, 8, 0, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl_fsm.md
Name: uart_rx_ctrl_fsm

Overview:
- Receive-side frame controller for the UART RX path.
- Detects the start bit and runs the per-bit oversampling edge counter and the data bit counter.
- Issues one-cycle enables to the data sampler, deserializer, start-glitch checker, parity checker and stop checker.
- Asserts data_valid only for frames with no start, parity or stop error. Sits in the UART RX clock domain, between the rx_in pin synchronizer and the checker/deserializer datapath.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the prescale input.

Ports:
- CLK  input  1  RX oversampling clock.
- RST  input  1  asynchronous active-low reset.
- rx_in  input  1  synchronized serial line; idle high.
- prescale  input  PRESCALE_W  oversampling ratio; 8, 16 or 32.
- par_en  input  1  frame carries a parity bit.
- strt_glitch  input  1  registered result of the start checker.
- par_err  input  1  registered result of the parity checker.
- stp_err  input  1  registered result of the stop checker.
- edge_cnt  output  PRESCALE_W  oversample index within the current bit.
- bit_cnt  output  4  data bit index.
- dat_samp_en  output  1  sampler enable.
- deser_en  output  1  deserializer shift pulse.
- strt_chk_en  output  1  start check pulse.
- par_chk_en  output  1  parity check pulse.
- stp_chk_en  output  1  stop check pulse.
- data_valid  output  1  frame accepted pulse.
- frm_err_cnt  output  8  stop-error frame count (see Optional Feature).

Behaviour:
- Clock and reset: CLK is the clock. RST is asynchronous, active-low. While RST=0, state=IDLE and every output and counter is 0.
- Prescale: P = prescale. Any value other than 8, 16 or 32 is treated as 8.
- Config latch: P and par_en are captured on the IDLE->START transition and held for the whole frame. Changes mid-frame are ignored.
- Bit end: edge_cnt counts 0..P-1 in START, DATA, PARITY and STOP. It wraps to 0 at P-1; that cycle is the bit end.
- Sampling: dat_samp_en=1 in START, DATA, PARITY and STOP, and 0 in IDLE.
- Check point: K = P/2+2. By this edge the sampler's triple sample (P/2-1, P/2, P/2+1) has completed.
- States and transitions:
  - IDLE: rx_in=0 -> START, with edge_cnt=0 and bit_cnt=0.
  - START: strt_chk_en pulses for 1 cycle at edge K. At bit end: strt_glitch=1 -> IDLE; otherwise -> DATA.
  - DATA: deser_en pulses at edge K. At bit end: if bit_cnt=DATA_WIDTH-1, go to PARITY when par_en=1, else STOP, and clear bit_cnt. Otherwise increment bit_cnt.
  - PARITY: par_chk_en pulses at edge K. At bit end -> STOP. No decision is taken here.
  - STOP: stp_chk_en pulses at edge K. At bit end -> IDLE. On that same edge, data_valid is set for exactly one cycle if strt_glitch=0, par_err=0 (or par_en=0) and stp_err=0.
- Checker latency: each checker updates one cycle after its enable pulse, so its result is stable from edge K+1. The controller reads results only at bit end (edge P-1 >= K+1, which holds for P>=8).
- Errored frames: data_valid stays 0 and the controller returns to IDLE. There is no sticky error flag.
- Back-to-back frames: a start bit that begins on the cycle after the stop bit end is detected from IDLE. This costs at most 1 cycle of skew, which is absorbed by the mid-bit sampling.
- rx_in low in IDLE straight after reset: treated as a start bit. A glitch is rejected by the start check.
- Line activity mid-frame: rx_in changes during DATA, PARITY or STOP do not alter sequencing.
- Reset mid-frame: immediately returns to IDLE with all outputs 0. No data_valid is produced for the aborted frame.

Optional Feature:
- Macro: UART_RX_FRM_ERR_CNT_EN.
- Defined: frm_err_cnt increments by 1 at each STOP bit end where stp_err=1. It saturates at 255 and is cleared only by RST.
- Undefined: frm_err_cnt is tied to 0 and no counter flops are built.

Test Plan:
- Basic frame: P=8, par_en=0, frame 0x A5 LSB first with stop=1 -> 8 deser_en pulses at edge 6 of each data bit; data_valid is a single pulse at the STOP bit end; no par_chk_en.
- Parity frame: P=16, par_en=1, even parity correct -> par_chk_en at edge 10 of bit 9; data_valid=1. Repeat with par_err forced to 1 from edge 11 -> data_valid stays 0 and state returns to IDLE.
- Stop error: P=32, stop bit=0 so stp_err=1 -> no data_valid. With UART_RX_FRM_ERR_CNT_EN, frm_err_cnt goes 0->1; 256 such frames -> holds at 255.
- Start glitch: rx_in low for 3 cycles at P=8, strt_glitch=1 -> return to IDLE at the end of START; deser_en never asserted.
- Back-to-back and config: two frames with no idle gap -> two data_valid pulses. Toggle par_en mid-frame -> the frame follows the latched par_en. prescale=12 -> behaves as P=8.
- Reset mid-DATA at bit 3: drive RST=0 -> all outputs 0 asynchronously. After release, a fresh frame is received correctly.
